sb_cfg_switch: RTL



---
 rtl/sb_cfg_pkg.sv | 37 +++
 rtl/sb_cfg_switch_if.sv | 39 +++
 rtl/sb_cfg_chain.sv | 100 ++++++++++
 rtl/sb_cfg_switch.sv | 67 ++++++
 4 files changed

// File: rtl/sb_cfg_pkg.sv
// ============================================================================
// Module  : sb_cfg_pkg
// Brief   : Shared types and index helpers for the configurable switch block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sb_cfg_pkg;

    // Load FSM: IDLE means cnt=0, LOADING is a partial chain, FULL is a complete chain
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } cfg_state_t;

    // Each mux owns two chain bits (sel, en), and there are 2*MUX_PER_SIDE muxes
    function automatic int cfg_bits(input int mux_per_side);
        return 4 * mux_per_side;
    endfunction

    function automatic int sel_idx(input int m);
        return 2 * m;
    endfunction

    function automatic int en_idx(input int m);
        return 2 * m + 1;
    endfunction

    // Channel track that feeds mux j: track 0 for the first mux, otherwise the top tracks
    function automatic int idx(input int chan_w, input int mux_per_side, input int j);
        return (j == 0) ? 0 : (chan_w - mux_per_side + j);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sb_cfg_switch_if.sv
// ============================================================================
// Module  : sb_cfg_switch_if
// Brief   : Channel, grid-pin and configuration-chain bundle of the switch block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sb_cfg_switch_if #(
    parameter int CHAN_W       = 9,
    parameter int MUX_PER_SIDE = 2
);
    logic                    ccff_head;
    logic                    cfg_shift_en;
    logic                    cfg_commit;
    logic [CHAN_W-1:0]       chany_top_in;
    logic [CHAN_W-1:0]       chanx_left_in;
    logic [MUX_PER_SIDE-1:0] top_pin_in;
    logic [MUX_PER_SIDE-1:0] left_pin_in;
    logic [CHAN_W-1:0]       chany_top_out;
    logic [CHAN_W-1:0]       chanx_left_out;
    logic                    ccff_tail;
    logic                    cfg_loaded;
    logic                    cfg_err;

    modport master (
        output ccff_head, cfg_shift_en, cfg_commit,
        output chany_top_in, chanx_left_in, top_pin_in, left_pin_in,
        input  chany_top_out, chanx_left_out, ccff_tail, cfg_loaded, cfg_err
    );

    modport slave (
        input  ccff_head, cfg_shift_en, cfg_commit,
        input  chany_top_in, chanx_left_in, top_pin_in, left_pin_in,
        output chany_top_out, chanx_left_out, ccff_tail, cfg_loaded, cfg_err
    );

endinterface

`default_nettype wire

// File: rtl/sb_cfg_chain.sv
// ============================================================================
// Module  : sb_cfg_chain
// Brief   : Shadow/active configuration chain with load-length checking FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_cfg_chain
    import sb_cfg_pkg::*;
#(
    parameter int CFG_BITS = 8
) (
    input  wire logic                prog_clk,
    input  wire logic                prog_rst_n,
    input  wire logic                ccff_head,
    input  wire logic                cfg_shift_en,
    input  wire logic                cfg_commit,
    output logic [CFG_BITS-1:0]      active,
    output logic                     ccff_tail,
    output logic                     cfg_loaded,
    output logic                     cfg_err
);

    localparam int                 c_CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(CFG_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    cfg_state_t          r_state,  w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [CFG_BITS-1:0] r_shadow, w_shadow_nxt;
    logic [CFG_BITS-1:0] r_active, w_active_nxt;
    logic                r_loaded, w_loaded_nxt;
    logic                r_err,    w_err_nxt;

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_active <= '0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_active <= w_active_nxt;
            r_loaded <= w_loaded_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_active_nxt = r_active;
        w_loaded_nxt = r_loaded;
        w_err_nxt    = r_err;

        // The chain moves on every shift, whatever the load state
        if (cfg_shift_en) begin
            w_shadow_nxt = {r_shadow[CFG_BITS-2:0], ccff_head};
        end

        case (r_state)
            IDLE, LOADING: begin
                if (cfg_shift_en) begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    w_state_nxt = (w_cnt_nxt == c_CNT_FULL) ? FULL : LOADING;
                end
                if (cfg_commit) begin
                    w_err_nxt = 1'b1;
                end
            end
            FULL: begin
                // Overflow keeps cnt pinned at CFG_BITS; a concurrent commit is refused
                if (cfg_shift_en) begin
                    w_err_nxt = 1'b1;
                end else if (cfg_commit) begin
                    w_active_nxt = r_shadow;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = IDLE;
                    w_loaded_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign active     = r_active;
    assign ccff_tail  = r_shadow[CFG_BITS-1];
    assign cfg_loaded = r_loaded;
    assign cfg_err    = r_err;

endmodule

`default_nettype wire

// File: rtl/sb_cfg_switch.sv
// ============================================================================
// Module  : sb_cfg_switch
// Brief   : Corner switch block: pass-through tracks plus gated config muxes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_cfg_switch
    import sb_cfg_pkg::*;
#(
    parameter int CHAN_W       = 9,
    parameter int MUX_PER_SIDE = 2
) (
    input  wire logic       prog_clk,
    input  wire logic       prog_rst_n,
    sb_cfg_switch_if.slave  sb
);

    localparam int c_CFG_BITS = cfg_bits(MUX_PER_SIDE);

    logic [c_CFG_BITS-1:0] w_active;

    if (MUX_PER_SIDE < 1 || CHAN_W < 2 * MUX_PER_SIDE) begin : g_bad_params
        $error("sb_cfg_switch: need MUX_PER_SIDE >= 1 and CHAN_W >= 2*MUX_PER_SIDE");
    end

    sb_cfg_chain #(
        .CFG_BITS (c_CFG_BITS)
    ) u_chain (
        .prog_clk     (prog_clk),
        .prog_rst_n   (prog_rst_n),
        .ccff_head    (sb.ccff_head),
        .cfg_shift_en (sb.cfg_shift_en),
        .cfg_commit   (sb.cfg_commit),
        .active       (w_active),
        .ccff_tail    (sb.ccff_tail),
        .cfg_loaded   (sb.cfg_loaded),
        .cfg_err      (sb.cfg_err)
    );

    // Straight-through tracks cross the corner with a twisted index
    for (genvar k = MUX_PER_SIDE; k < CHAN_W; k++) begin : g_pass
        assign sb.chanx_left_out[k] = sb.chany_top_in[CHAN_W-k];
        assign sb.chany_top_out[k]  = sb.chanx_left_in[CHAN_W-k];
    end

    // Top mux j is global mux j; left mux j is global mux MUX_PER_SIDE+j
    for (genvar j = 0; j < MUX_PER_SIDE; j++) begin : g_mux
        localparam int c_SRC = idx(CHAN_W, MUX_PER_SIDE, j);
        localparam int c_MT  = j;
        localparam int c_ML  = MUX_PER_SIDE + j;

        logic w_top_sel;
        logic w_left_sel;

        assign w_top_sel  = w_active[sel_idx(c_MT)] ? sb.top_pin_in[j]
                                                    : sb.chanx_left_in[c_SRC];
        assign w_left_sel = w_active[sel_idx(c_ML)] ? sb.chany_top_in[c_SRC]
                                                    : sb.left_pin_in[j];

        assign sb.chany_top_out[j]  = w_active[en_idx(c_MT)] & w_top_sel;
        assign sb.chanx_left_out[j] = w_active[en_idx(c_ML)] & w_left_sel;
    end

endmodule

`default_nettype wire
